// File: rtl/serial_arith_pkg.sv
// Shared types and the digit add/subtract helper for the digit-serial
// arithmetic blocks.
package serial_arith_pkg;

  // Widest digit the helper function can evaluate.
  localparam int DW_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_t;

  // Ripple add/subtract of the low w bits of a and b.
  // Returns {cout, cmsb, sum}, where cmsb is the carry into bit w-1.
  // Sum bits at and above w are returned as zero.
  function automatic logic [DW_MAX+1:0] digit_addsub(
    input logic [DW_MAX-1:0] a,
    input logic [DW_MAX-1:0] b,
    input logic              cin,
    input mode_t             mode,
    input int                w
  );
    logic [DW_MAX-1:0] sum;
    logic              c;
    logic              cmsb;
    logic              bb;
    sum  = {DW_MAX{1'b0}};
    c    = cin;
    cmsb = 1'b0;
    bb   = 1'b0;
    for (int i = 0; i < DW_MAX; i++) begin
      if (i < w) begin
        bb = (mode == MODE_SUB) ? ~b[i] : b[i];
        if (i == (w - 1)) begin
          cmsb = c;
        end else begin
          cmsb = cmsb;
        end
        sum[i] = a[i] ^ bb ^ c;
        c      = (a[i] & bb) | (a[i] & c) | (bb & c);
      end else begin
        sum[i] = 1'b0;
      end
    end
    return {c, cmsb, sum};
  endfunction

endpackage

// File: rtl/serial_digit_cell.sv
// Combinational DIGIT_W-bit add/subtract cell. In subtract mode b is
// inverted; the caller supplies carry-in 1 on the first digit.
module serial_digit_cell
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  mode_t              mode,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);

  logic [DW_MAX-1:0] a_ext_s;
  logic [DW_MAX-1:0] b_ext_s;
  logic [DW_MAX+1:0] res_s;
  logic              unused_res_s;

  // Zero-extend the digits and evaluate the shared add/subtract helper.
  always_comb begin
    a_ext_s                = {DW_MAX{1'b0}};
    b_ext_s                = {DW_MAX{1'b0}};
    a_ext_s[DIGIT_W-1:0]   = a;
    b_ext_s[DIGIT_W-1:0]   = b;
    res_s                  = digit_addsub(a_ext_s, b_ext_s, cin, mode, DIGIT_W);
  end

  assign sum          = res_s[DIGIT_W-1:0];
  assign cmsb         = res_s[DW_MAX];
  assign cout         = res_s[DW_MAX+1];
  // Upper sum bits are always zero; fold them so nothing dangles.
  assign unused_res_s = ^res_s;

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: one digit pair per valid cycle, LSB first,
// framed by vld/last. Streams result digits one cycle later and presents the
// assembled result, final carry, overflow and length status at frame end.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter  int DIGIT_W    = 4,
  parameter  int MAX_DIGITS = 8,
  localparam int RES_W      = DIGIT_W * MAX_DIGITS,
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               sub,
  input  logic               last,
  output logic               out_vld,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               carry_out,
  output logic               ovf,
  output logic               res_vld,
  output logic [RES_W-1:0]   res,
  output logic [CNT_W-1:0]   res_len,
  output logic               err_len
);

  state_t             state_r;
  state_t             state_next_s;
  mode_t              mode_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [RES_W-1:0]   buf_r;
  logic               err_r;

  mode_t              mode_eff_s;
  logic               cin_s;
  logic [CNT_W-1:0]   cnt_base_s;
  logic               err_base_s;
  logic [RES_W-1:0]   buf_base_s;
  logic               fits_s;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               err_next_s;
  logic [RES_W-1:0]   buf_next_s;
  logic [DIGIT_W-1:0] sum_s;
  logic               cout_s;
  logic               cmsb_s;

  serial_digit_cell #(
    .DIGIT_W (DIGIT_W)
  ) u_cell (
    .a    (a),
    .b    (b),
    .cin  (cin_s),
    .mode (mode_eff_s),
    .sum  (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // Frame tracking: a digit with last closes the frame, any other digit opens it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (vld && !last) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (vld && last) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // First digit of a frame takes mode and carry-in from sub and starts from a
  // clean count/buffer; later digits continue from the registered frame state.
  always_comb begin
    mode_eff_s = mode_r;
    cin_s      = carry_r;
    cnt_base_s = cnt_r;
    err_base_s = err_r;
    buf_base_s = buf_r;
    if (state_r == IDLE) begin
      mode_eff_s = mode_t'(sub);
      cin_s      = sub;
      cnt_base_s = {CNT_W{1'b0}};
      err_base_s = 1'b0;
      buf_base_s = {RES_W{1'b0}};
    end else begin
      mode_eff_s = mode_r;
      cin_s      = carry_r;
      cnt_base_s = cnt_r;
      err_base_s = err_r;
      buf_base_s = buf_r;
    end
  end

  // Store the digit into its slot while there is room; otherwise flag overrun.
  always_comb begin
    fits_s     = (cnt_base_s < CNT_W'(MAX_DIGITS));
    buf_next_s = buf_base_s;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (fits_s && (cnt_base_s == CNT_W'(k))) begin
        buf_next_s[k*DIGIT_W +: DIGIT_W] = sum_s;
      end else begin
        buf_next_s[k*DIGIT_W +: DIGIT_W] = buf_base_s[k*DIGIT_W +: DIGIT_W];
      end
    end
    if (fits_s) begin
      cnt_next_s = cnt_base_s + CNT_W'(1);
      err_next_s = err_base_s;
    end else begin
      cnt_next_s = cnt_base_s;
      err_next_s = 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Per-frame datapath state; only advances on valid digits so gaps hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r  <= MODE_ADD;
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      buf_r   <= {RES_W{1'b0}};
      err_r   <= 1'b0;
    end else if (vld) begin
      mode_r  <= mode_eff_s;
      carry_r <= cout_s;
      cnt_r   <= cnt_next_s;
      buf_r   <= buf_next_s;
      err_r   <= err_next_s;
    end else begin
      mode_r  <= mode_r;
      carry_r <= carry_r;
      cnt_r   <= cnt_r;
      buf_r   <= buf_r;
      err_r   <= err_r;
    end
  end

  // Streamed digit outputs, one cycle behind the input digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_digit <= {DIGIT_W{1'b0}};
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_vld  <= vld;
      out_last <= vld & last;
      if (vld) begin
        out_digit <= sum_s;
        carry_out <= cout_s;
        ovf       <= cout_s ^ cmsb_s;
      end else begin
        out_digit <= out_digit;
        carry_out <= carry_out;
        ovf       <= ovf;
      end
    end
  end

  // Frame result outputs, published on the cycle after the last digit and held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld <= 1'b0;
      res     <= {RES_W{1'b0}};
      res_len <= {CNT_W{1'b0}};
      err_len <= 1'b0;
    end else begin
      res_vld <= vld & last;
      if (vld && last) begin
        res     <= buf_next_s;
        res_len <= cnt_next_s;
        err_len <= err_next_s;
      end else begin
        res     <= res;
        res_len <= res_len;
        err_len <= err_len;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Self-checking bench for serial_addsub_digit (DIGIT_W=4, MAX_DIGITS=4).
module tb_serial_addsub_digit;

  localparam int DW    = 4;
  localparam int MD    = 4;
  localparam int RW    = DW * MD;
  localparam int CW    = $clog2(MD + 1);

  logic          clk;
  logic          rst;
  logic          vld;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          sub;
  logic          last;
  logic          out_vld;
  logic [DW-1:0] out_digit;
  logic          out_last;
  logic          carry_out;
  logic          ovf;
  logic          res_vld;
  logic [RW-1:0] res;
  logic [CW-1:0] res_len;
  logic          err_len;

  serial_addsub_digit #(
    .DIGIT_W    (DW),
    .MAX_DIGITS (MD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .last      (last),
    .out_vld   (out_vld),
    .out_digit (out_digit),
    .out_last  (out_last),
    .carry_out (carry_out),
    .ovf       (ovf),
    .res_vld   (res_vld),
    .res       (res),
    .res_len   (res_len),
    .err_len   (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          vld;
    logic          sub;
    logic          last;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] e_digit;
    logic          e_carry;
    logic          e_ovf;
    logic [RW-1:0] e_res;
    logic [CW-1:0] e_len;
    logic          e_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] digit;
    logic          last;
    logic          carry;
    logic          ovf;
    logic [RW-1:0] res;
    logic [CW-1:0] len;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  vec_t          tbl[$];
  int            n_total;
  int            n_pass;
  logic [DW-1:0] hold_digit;
  logic          hold_carry;
  logic          hold_ovf;
  logic [RW-1:0] hold_res;
  logic [CW-1:0] hold_len;
  logic          hold_err;

  function automatic vec_t mk(input logic r, input logic v, input logic s, input logic l,
                              input logic [DW-1:0] aa, input logic [DW-1:0] bb,
                              input logic [DW-1:0] ed, input logic ec, input logic eo,
                              input logic [RW-1:0] er, input logic [CW-1:0] el,
                              input logic ee);
    vec_t t;
    t.rst = r; t.vld = v; t.sub = s; t.last = l; t.a = aa; t.b = bb;
    t.e_digit = ed; t.e_carry = ec; t.e_ovf = eo; t.e_res = er; t.e_len = el; t.e_err = ee;
    return t;
  endfunction

  // Digit row (no reset), optional last with frame expectations.
  function automatic vec_t dg(input logic s, input logic l, input logic [DW-1:0] aa,
                              input logic [DW-1:0] bb, input logic [DW-1:0] ed,
                              input logic ec, input logic eo, input logic [RW-1:0] er,
                              input logic [CW-1:0] el, input logic ee);
    return mk(1'b0, 1'b1, s, l, aa, bb, ed, ec, eo, er, el, ee);
  endfunction

  function automatic vec_t gap(input logic l);
    return mk(1'b0, 1'b0, 1'b1, l, 4'h5, 4'hA, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
  endfunction

  function automatic vec_t rs(input logic v);
    return mk(1'b1, v, 1'b1, v, 4'h3, 4'h4, 4'h0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    rst  = v.rst;
    vld  = v.vld;
    a    = v.a;
    b    = v.b;
    sub  = v.sub;
    last = v.last;
    if (!v.rst && v.vld) begin
      e.digit = v.e_digit; e.last = v.last; e.carry = v.e_carry; e.ovf = v.e_ovf;
      e.res = v.e_res; e.len = v.e_len; e.err = v.e_err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      exp_q.delete();
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_out_digit", 32'(out_digit), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_carry_out", 32'(carry_out), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_res_vld", 32'(res_vld), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      check("rst_res_len", 32'(res_len), 32'd0);
      check("rst_err_len", 32'(err_len), 32'd0);
      hold_digit = 4'h0; hold_carry = 1'b0; hold_ovf = 1'b0;
      hold_res = 16'h0000; hold_len = 3'd0; hold_err = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_vld", 32'(out_vld), 32'd1);
      check("out_digit", 32'(out_digit), 32'(e.digit));
      check("out_last", 32'(out_last), 32'(e.last));
      check("res_vld", 32'(res_vld), 32'(e.last));
      hold_digit = e.digit;
      if (e.last) begin
        check("carry_out", 32'(carry_out), 32'(e.carry));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("res", 32'(res), 32'(e.res));
        check("res_len", 32'(res_len), 32'(e.len));
        check("err_len", 32'(err_len), 32'(e.err));
        hold_carry = e.carry; hold_ovf = e.ovf;
        hold_res = e.res; hold_len = e.len; hold_err = e.err;
      end else begin
        check("res_hold_mid", 32'(res), 32'(hold_res));
      end
    end else begin
      check("gap_out_vld", 32'(out_vld), 32'd0);
      check("gap_out_last", 32'(out_last), 32'd0);
      check("gap_res_vld", 32'(res_vld), 32'd0);
      check("gap_digit_hold", 32'(out_digit), 32'(hold_digit));
      check("gap_res_hold", 32'(res), 32'(hold_res));
      check("gap_len_hold", 32'(res_len), 32'(hold_len));
      check("gap_err_hold", 32'(err_len), 32'(hold_err));
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    hold_digit = 4'h0; hold_carry = 1'b0; hold_ovf = 1'b0;
    hold_res = 16'h0000; hold_len = 3'd0; hold_err = 1'b0;
    rst = 1'b1; vld = 1'b0; a = 4'h0; b = 4'h0; sub = 1'b0; last = 1'b0;

    // Table: reset, then self-contained frames.
    tbl.push_back(rs(1'b0));
    tbl.push_back(rs(1'b0));
    tbl.push_back(gap(1'b0));
    // 0x1234 + 0x0FFF
    tbl.push_back(dg(1'b0, 1'b0, 4'h4, 4'hF, 4'h3, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b0, 4'h3, 4'hF, 4'h3, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b0, 4'h2, 4'hF, 4'h2, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b1, 4'h1, 4'h0, 4'h2, 1'b0, 1'b0, 16'h2233, 3'd4, 1'b0));
    tbl.push_back(gap(1'b0));
    // 0x05 - 0x07, sub only on first digit
    tbl.push_back(dg(1'b1, 1'b0, 4'h5, 4'h7, 4'hE, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b1, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 16'h00FE, 3'd2, 1'b0));
    // 0x7F + 0x01 signed overflow
    tbl.push_back(dg(1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b1, 4'h7, 4'h0, 4'h8, 1'b0, 1'b1, 16'h0080, 3'd2, 1'b0));
    // 0x80 - 0x01 signed overflow
    tbl.push_back(dg(1'b1, 1'b0, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    tbl.push_back(dg(1'b0, 1'b1, 4'h8, 4'h0, 4'h7, 1'b1, 1'b1, 16'h007F, 3'd2, 1'b0));
    // Single-digit frame 9 + 8
    tbl.push_back(dg(1'b0, 1'b1, 4'h9, 4'h8, 4'h1, 1'b1, 1'b1, 16'h0001, 3'd1, 1'b0));
    tbl.push_back(gap(1'b0));
    // Five-digit frame overruns a 4-digit buffer
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(dg(1'b0, 1'b0, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    end
    tbl.push_back(dg(1'b0, 1'b1, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 16'h2222, 3'd4, 1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Gapped repeat of 0x1234 + 0x0FFF with a stray last and stray sub in gaps.
    apply(dg(1'b0, 1'b0, 4'h4, 4'hF, 4'h3, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(gap(1'b0));
    apply(gap(1'b1));
    apply(gap(1'b0));
    apply(dg(1'b1, 1'b0, 4'h3, 4'hF, 4'h3, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(gap(1'b0));
    apply(gap(1'b0));
    apply(gap(1'b0));
    apply(dg(1'b1, 1'b0, 4'h2, 4'hF, 4'h2, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(gap(1'b0));
    apply(gap(1'b1));
    apply(gap(1'b0));
    apply(dg(1'b0, 1'b1, 4'h1, 4'h0, 4'h2, 1'b0, 1'b0, 16'h2233, 3'd4, 1'b0));
    apply(gap(1'b0));

    // Reset in the middle of a subtract frame, with vld/last asserted.
    apply(dg(1'b1, 1'b0, 4'h5, 4'h7, 4'hE, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(dg(1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(rs(1'b1));
    apply(gap(1'b0));

    // Back-to-back frames with no bubble: add, sub, add.
    apply(dg(1'b0, 1'b1, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 16'h0002, 3'd1, 1'b0));
    apply(dg(1'b1, 1'b1, 4'h3, 4'h1, 4'h2, 1'b1, 1'b0, 16'h0002, 3'd1, 1'b0));
    apply(dg(1'b0, 1'b0, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0, 16'h0, 3'd0, 1'b0));
    apply(dg(1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 16'h000F, 3'd2, 1'b0));
    apply(gap(1'b0));
    apply(gap(1'b0));

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
- Digit-serial adder/subtractor. Consumes one DIGIT_W-bit digit pair per valid cycle, LSB digit first, framed by vld/last.
- Streams one result digit per valid input digit. On the frame's last digit it also presents the assembled parallel result, final carry, signed overflow and length status.
- Parametrised successor of the 1-bit serial adder in the sequential-basics block set. Adds multi-bit digits, subtraction, frame length tracking and result buffering.

Parameters:
- DIGIT_W, 4, bits per digit (>=1)
- MAX_DIGITS, 8, max digits stored in res per frame (>=1)
- RES_W (localparam), DIGIT_W*MAX_DIGITS, width of res
- CNT_W (localparam), $clog2(MAX_DIGITS+1), width of res_len

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- vld  in  1  input digit valid
- a  in  DIGIT_W  operand A digit
- b  in  DIGIT_W  operand B digit
- sub  in  1  mode: 0 add, 1 subtract (A-B); sampled on first digit of frame only
- last  in  1  final digit of frame; qualified by vld
- out_vld  out  1  out_digit valid
- out_digit  out  DIGIT_W  result digit
- out_last  out  1  out_digit is final digit of frame
- carry_out  out  1  final carry (add) / not-borrow (sub); valid when out_last=1
- ovf  out  1  two's-complement overflow; valid when out_last=1
- res_vld  out  1  one-cycle pulse: res/res_len/err_len updated
- res  out  RES_W  assembled result, digit k at res[k*DIGIT_W +: DIGIT_W]
- res_len  out  CNT_W  digits stored in res (<= MAX_DIGITS)
- err_len  out  1  frame exceeded MAX_DIGITS; valid with res_vld, held after

Behaviour:
- States IDLE (no frame open) and BUSY (frame open).
  - IDLE & vld & !last -> BUSY.
  - IDLE & vld & last -> IDLE (single-digit frame).
  - BUSY & vld & last -> IDLE.
  - Otherwise state holds.
- First digit (vld in IDLE):
  - mode latched from sub.
  - Carry-in = sub (0 add, 1 sub).
  - Digit count, err flag and res assembly buffer cleared before storing.
  - Later digits ignore sub and use the latched mode.
- Per-digit arithmetic: {c_msb_out, s} = a + (mode ? ~b : b) + carry. The carry register updates only on vld cycles and holds across vld=0 gaps.
- ovf = carry into the digit MSB XOR carry out of the MSB, computed on the last digit.
- Latency: all outputs registered, exactly 1 cycle after the input digit.
  - out_vld = registered vld.
  - out_last = registered (vld & last).
  - When vld=0: out_vld=0, out_last=0; out_digit, carry_out and ovf hold.
- last with vld=0 is ignored entirely.
- Result buffer:
  - Digit k (k < MAX_DIGITS) is written into buffer slot k. Unwritten upper slots are 0.
  - Digits beyond MAX_DIGITS are streamed on out_digit but not stored, and set err.
- On vld & last, next cycle:
  - res_vld=1.
  - res = buffer including the final digit if it fits.
  - res_len = min(count, MAX_DIGITS).
  - err_len = err.
  - res, res_len and err_len then hold until the next res_vld.
- Reset, including mid-frame:
  - Next cycle: state IDLE, carry 0, count 0, buffer 0.
  - All outputs 0 (out_vld, out_digit, out_last, carry_out, ovf, res_vld, res, res_len, err_len).
  - A partial frame is discarded with no res_vld. rst has priority over vld.
- Back-to-back frames (last then vld next cycle) are supported with no bubble. The new frame starts with fresh carry and mode.

Decomposition:
- Package serial_arith_pkg:
  - state enum {IDLE, BUSY}.
  - mode enum {MODE_ADD, MODE_SUB}.
  - Function digit_addsub(a, b, cin, mode) returning {cout, cmsb, sum}.
- One combinational sub-module, serial_digit_cell: DIGIT_W-bit add/sub cell with carry-into-MSB output.
- FSM, counter, buffer and output registers live in the top.

Test Plan (DIGIT_W=4, MAX_DIGITS=4 unless noted):
- Add 0x1234+0x0FFF, 4 digits: a=4,3,2,1; b=F,F,F,0; last on 4th -> out_digit 3,3,2,2; out_last on 4th; res=0x2233, res_len=4, carry_out=0, ovf=0, err_len=0.
- Sub 2 digits, sub=1 on first only: a=5,0; b=7,0 -> digits E,F; res=0x00FE, res_len=2, carry_out=0 (borrow), ovf=0.
- Signed overflow, add: a=F,7; b=1,0 (0x7F+0x01) -> res=0x0080, ovf=1, carry_out=0. Sub case: 0x80-0x01 -> res=0x007F, ovf=1.
- Gaps and stray last:
  - Repeat the first test with 3 vld=0 cycles between digits, last=1 during one gap -> identical results; out_vld low in gaps; gap-cycle last ignored.
  - Single-digit frame a=9, b=8, last -> out_digit 1, carry_out=1, res=0x0001.
- Length overflow: 5 digits, all a=1, b=1 -> out_digit 2 five times; res=0x2222, res_len=4, err_len=1.
- Reset recovery and back-to-back:
  - rst after 2 digits of a sub frame -> no res_vld, outputs 0.
  - Then add frame a=1, b=1, last -> res=0x0002, carry 0, ovf 0.
  - Immediately follow with another frame -> correct result, no bubble.
